// File: rtl/multi_road_traffic_controller_pkg.sv
// Shared definitions for the N-road traffic-light sequencer.
//   phase_t : 2-bit phase code presented on the phase output
//             (00 all roads red, 01 active road green, 10 active road yellow).
package multi_road_traffic_controller_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_t;

endpackage

// File: rtl/multi_road_traffic_controller_if.sv
// Signal bundle between the traffic system top (master) and the sequencer (slave).
//   ped_req, emergency          : requests into the sequencer
//   red, yellow, green          : per-road lamps
//   active_road, phase          : road owning (or next to own) green, current phase code
//   time_remaining, ped_pending : phase timer value, latched pedestrian flags
interface multi_road_traffic_controller_if #(
    parameter int N_ROADS = 3,
    parameter int CNT_W   = 7
);
    import multi_road_traffic_controller_pkg::*;

    localparam int RW = $clog2(N_ROADS);

    logic [N_ROADS-1:0] ped_req;
    logic               emergency;
    logic [N_ROADS-1:0] red;
    logic [N_ROADS-1:0] yellow;
    logic [N_ROADS-1:0] green;
    logic [RW-1:0]      active_road;
    phase_t             phase;
    logic [CNT_W-1:0]   time_remaining;
    logic [N_ROADS-1:0] ped_pending;

    modport master (
        output ped_req, emergency,
        input  red, yellow, green, active_road, phase, time_remaining, ped_pending
    );

    modport slave (
        input  ped_req, emergency,
        output red, yellow, green, active_road, phase, time_remaining, ped_pending
    );

endinterface

// File: rtl/multi_road_traffic_controller_phase_timer.sv
// Phase down-counter with terminal-count flag.
//   load/load_val : reload with (duration - 1) on phase entry
//   hold          : freeze the count
//   value         : current count, saturates at 0
//   zero          : count has reached 0 (last cycle of the phase)
module multi_road_traffic_controller_phase_timer #(
    parameter int               CNT_W   = 7,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (!hold && value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/multi_road_traffic_controller.sv
// Round-robin N-road traffic-light sequencer: GREEN -> YELLOW -> ALL_RED -> next road.
// Pedestrian requests are latched per road and may cut the active road's green
// once it has run MIN_GREEN cycles; emergency forces everything to red.
//   clk, rst_n : 1 Hz system clock, async active-low reset
//   bus        : slave side of multi_road_traffic_controller_if
//
// State table:
//   state      | meaning
//   PH_ALL_RED | every road red; clearance, or parked while emergency is high
//   PH_GREEN   | active_road green, all others red
//   PH_YELLOW  | active_road yellow, all others red; never truncated
module multi_road_traffic_controller
    import multi_road_traffic_controller_pkg::*;
#(
    parameter int N_ROADS     = 3,
    parameter int CNT_W       = 7,
    parameter int GREEN_TIME  = 120,
    parameter int YELLOW_TIME = 30,
    parameter int ALLRED_TIME = 3,
    parameter int MIN_GREEN   = 10
) (
    input logic clk,
    input logic rst_n,
    multi_road_traffic_controller_if.slave bus
);

    localparam int               RW          = $clog2(N_ROADS);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TIME - 1);
    // Timer value at or below which green has already run MIN_GREEN cycles.
    localparam logic [CNT_W-1:0] EARLY_LIMIT = CNT_W'(GREEN_TIME - MIN_GREEN);
    localparam logic [RW-1:0]    LAST_ROAD   = RW'(N_ROADS - 1);

    phase_t             state;
    phase_t             state_nxt;
    logic [RW-1:0]      road;
    logic [N_ROADS-1:0] pending;
    logic [N_ROADS-1:0] clr_mask;

    logic               t_load;
    logic               t_hold;
    logic               t_zero;
    logic [CNT_W-1:0]   t_load_val;
    logic [CNT_W-1:0]   t_value;

    logic               road_adv;
    logic               ped_clr;
    logic               early;

    logic [N_ROADS-1:0] red_c;
    logic [N_ROADS-1:0] yellow_c;
    logic [N_ROADS-1:0] green_c;

    multi_road_traffic_controller_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LOAD)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_load_val),
        .hold     (t_hold),
        .value    (t_value),
        .zero     (t_zero)
    );

    assign early    = pending[road] && (t_value <= EARLY_LIMIT);
    // Parks the timer explicitly while all-red is extended by an emergency.
    assign t_hold   = (state == PH_ALL_RED) && bus.emergency && t_zero;
    assign clr_mask = ped_clr ? (N_ROADS'(1) << road) : '0;

    always_comb begin
        state_nxt  = state;
        t_load     = 1'b0;
        t_load_val = '0;
        road_adv   = 1'b0;
        ped_clr    = 1'b0;
        case (state)
            PH_ALL_RED: begin
                if (t_zero && !bus.emergency) begin
                    state_nxt  = PH_GREEN;
                    t_load     = 1'b1;
                    t_load_val = GREEN_LOAD;
                end
            end
            PH_GREEN: begin
                if (bus.emergency || t_zero || early) begin
                    state_nxt  = PH_YELLOW;
                    t_load     = 1'b1;
                    t_load_val = YELLOW_LOAD;
                    ped_clr    = 1'b1;
                end
            end
            PH_YELLOW: begin
                if (t_zero) begin
                    state_nxt  = PH_ALL_RED;
                    t_load     = 1'b1;
                    t_load_val = ALLRED_LOAD;
                    road_adv   = 1'b1;
                end
            end
            default: begin
                state_nxt  = PH_ALL_RED;
                t_load     = 1'b1;
                t_load_val = ALLRED_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PH_ALL_RED;
            road    <= '0;
            pending <= '0;
        end else begin
            state <= state_nxt;
            if (road_adv) begin
                road <= (road == LAST_ROAD) ? '0 : road + 1'b1;
            end
            // New requests are OR-ed in after the clear so a same-cycle set wins.
            pending <= (pending & ~clr_mask) | bus.ped_req;
        end
    end

    always_comb begin
        red_c    = '1;
        yellow_c = '0;
        green_c  = '0;
        if (state == PH_GREEN) begin
            red_c[road]   = 1'b0;
            green_c[road] = 1'b1;
        end else if (state == PH_YELLOW) begin
            red_c[road]    = 1'b0;
            yellow_c[road] = 1'b1;
        end
    end

    assign bus.red            = red_c;
    assign bus.yellow         = yellow_c;
    assign bus.green          = green_c;
    assign bus.active_road    = road;
    assign bus.phase          = state;
    assign bus.time_remaining = t_value;
    assign bus.ped_pending    = pending;

endmodule

// File: tb/tb_multi_road_traffic_controller.sv
// Bench for multi_road_traffic_controller: directed scenarios with absolute
// cycle checks plus randomized requests/emergencies, every cycle compared
// against an elapsed-time reference model.
module tb_multi_road_traffic_controller;
    import multi_road_traffic_controller_pkg::*;

    localparam int N       = 3;
    localparam int CNT_W   = 7;
    localparam int GREEN   = 8;
    localparam int YELLOW  = 3;
    localparam int ALLRED  = 2;
    localparam int MIN_GRN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_road_traffic_controller_if #(.N_ROADS(N), .CNT_W(CNT_W)) bus ();

    multi_road_traffic_controller #(
        .N_ROADS     (N),
        .CNT_W       (CNT_W),
        .GREEN_TIME  (GREEN),
        .YELLOW_TIME (YELLOW),
        .ALLRED_TIME (ALLRED),
        .MIN_GREEN   (MIN_GRN)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 all-red, 1 green, 2 yellow; m_el = cycles already spent in phase.
    int       m_ph;
    int       m_road;
    int       m_el;
    bit       m_ped [N];

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_dur(input int ph);
        if (ph == 1) return GREEN;
        if (ph == 2) return YELLOW;
        return ALLRED;
    endfunction

    function automatic int m_rem();
        int r;
        r = m_dur(m_ph) - 1 - m_el;
        return (r < 0) ? 0 : r;
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_road = 0;
        m_el   = 0;
        for (int i = 0; i < N; i++) m_ped[i] = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic em);
        int clr;
        clr = -1;
        case (m_ph)
            0: begin
                if (m_el >= ALLRED - 1 && !em) begin
                    m_ph = 1;
                    m_el = 0;
                end else begin
                    m_el++;
                end
            end
            1: begin
                // Pedestrian cut allowed once green has been on MIN_GRN cycles.
                if (em || m_el == GREEN - 1 || (m_ped[m_road] && m_el >= MIN_GRN - 1)) begin
                    clr  = m_road;
                    m_ph = 2;
                    m_el = 0;
                end else begin
                    m_el++;
                end
            end
            default: begin
                if (m_el == YELLOW - 1) begin
                    m_ph   = 0;
                    m_el   = 0;
                    m_road = (m_road + 1) % N;
                end else begin
                    m_el++;
                end
            end
        endcase
        for (int i = 0; i < N; i++) begin
            if (clr == i) m_ped[i] = 1'b0;
            if (req[i])   m_ped[i] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_p, exp_r, exp_y, exp_g;
        for (int i = 0; i < N; i++) begin
            exp_p[i] = m_ped[i];
            exp_r[i] = !(m_ph != 0 && i == m_road);
            exp_g[i] = (m_ph == 1 && i == m_road);
            exp_y[i] = (m_ph == 2 && i == m_road);
        end
        check_val("phase",   int'(bus.phase), m_ph);
        check_val("road",    int'(bus.active_road), m_road);
        check_val("time",    int'(bus.time_remaining), m_rem());
        check_val("pending", int'(bus.ped_pending), int'(exp_p));
        check_val("red",     int'(bus.red), int'(exp_r));
        check_val("yellow",  int'(bus.yellow), int'(exp_y));
        check_val("green",   int'(bus.green), int'(exp_g));
    endtask

    task automatic at_negedge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_edge(input logic [N-1:0] req, input logic em);
        bus.ped_req   = req;
        bus.emergency = em;
        @(posedge clk);
        model_step(req, em);
    endtask

    // Leaves the bench just after a posedge, so the next negedge is cycle 0.
    task automatic do_reset();
        rst_n         = 1'b0;
        bus.ped_req   = '0;
        bus.emergency = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] req;
        logic         em;

        // Free run from reset, including wrap back to road 0.
        do_reset();
        for (int c = 0; c < 45; c++) begin
            at_negedge();
            if (c == 0)  begin
                check_val("rst_red", int'(bus.red), 7);
                check_val("rst_time", int'(bus.time_remaining), 1);
            end
            if (c == 2)  begin
                check_val("fr_c2_green", int'(bus.green), 1);
                check_val("fr_c2_time", int'(bus.time_remaining), 7);
            end
            if (c == 9)  check_val("fr_c9_green", int'(bus.green), 1);
            if (c == 10) begin
                check_val("fr_c10_yellow", int'(bus.yellow), 1);
                check_val("fr_c10_time", int'(bus.time_remaining), 2);
            end
            if (c == 13) begin
                check_val("fr_c13_red", int'(bus.red), 7);
                check_val("fr_c13_road", int'(bus.active_road), 1);
            end
            if (c == 15) check_val("fr_c15_green", int'(bus.green), 2);
            if (c == 41) begin
                check_val("fr_wrap_road", int'(bus.active_road), 0);
                check_val("fr_wrap_green", int'(bus.green), 1);
            end
            drive_edge('0, 1'b0);
        end

        // Pedestrian on road 0 during its first green cycle: green cut at 4.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            at_negedge();
            if (c == 3) check_val("ped0_set", int'(bus.ped_pending), 1);
            if (c == 5) check_val("ped0_c5_green", int'(bus.green), 1);
            if (c == 6) begin
                check_val("ped0_c6_yellow", int'(bus.yellow), 1);
                check_val("ped0_c6_time", int'(bus.time_remaining), 2);
                check_val("ped0_c6_clr", int'(bus.ped_pending), 0);
            end
            drive_edge((c == 2) ? 3'b001 : 3'b000, 1'b0);
        end

        // Pedestrian on road 2 during road 0 green: road 0 full, road 2 cut.
        do_reset();
        for (int c = 0; c < 35; c++) begin
            at_negedge();
            if (c == 9)  check_val("ped2_r0_full", int'(bus.green), 1);
            if (c == 20) check_val("ped2_held", int'(bus.ped_pending), 4);
            if (c == 31) begin
                check_val("ped2_c31_green", int'(bus.green), 4);
                check_val("ped2_c31_pend", int'(bus.ped_pending), 4);
            end
            if (c == 32) check_val("ped2_c32_yellow", int'(bus.yellow), 4);
            drive_edge((c == 3) ? 3'b100 : 3'b000, 1'b0);
        end

        // Emergency in road 1 green cycle 2, held long, then released.
        do_reset();
        for (int c = 0; c < 45; c++) begin
            at_negedge();
            if (c == 17) begin
                check_val("em_c17_yellow", int'(bus.yellow), 2);
                check_val("em_c17_time", int'(bus.time_remaining), 2);
            end
            if (c == 19) check_val("em_c19_time", int'(bus.time_remaining), 0);
            if (c == 35) begin
                check_val("em_hold_red", int'(bus.red), 7);
                check_val("em_hold_road", int'(bus.active_road), 2);
                check_val("em_hold_time", int'(bus.time_remaining), 0);
            end
            if (c == 41) check_val("em_resume_green", int'(bus.green), 4);
            drive_edge('0, (c >= 16 && c < 40));
        end

        // Road 1 request held across its own GREEN->YELLOW edge: set wins.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            at_negedge();
            if (c == 19) begin
                check_val("setwin_phase", int'(bus.phase), 2);
                check_val("setwin_pend1", int'(bus.ped_pending[1]), 1);
            end
            drive_edge((c >= 14 && c <= 20) ? 3'b010 : 3'b000, 1'b0);
        end

        // Reset asserted mid-yellow.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            at_negedge();
            drive_edge((c == 3) ? 3'b100 : 3'b000, 1'b0);
        end
        at_negedge();
        rst_n = 1'b0;
        #1;
        check_val("mr_red", int'(bus.red), 7);
        check_val("mr_yellow", int'(bus.yellow), 0);
        check_val("mr_green", int'(bus.green), 0);
        check_val("mr_phase", int'(bus.phase), 0);
        check_val("mr_road", int'(bus.active_road), 0);
        check_val("mr_time", int'(bus.time_remaining), 1);
        check_val("mr_pend", int'(bus.ped_pending), 0);

        // Randomized requests and emergency bursts.
        do_reset();
        em = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            at_negedge();
            req = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) req[i] = 1'b1;
            end
            if ($urandom_range(39) == 0) em = !em;
            drive_edge(req, em);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
